// File: rtl/qspi_cmd_shifter.sv
// qspi_cmd_shifter: QSPI opcode/address/dummy serialiser (ports: clk, reset, start_i, cmd_i, addr_i, addr_en_i, addr_lanes_i, dummy_i, release_i -> sclk_o, cs_n_o, io_o, io_oe_o, busy_o, done_o)
module qspi_cmd_shifter #(
  parameter int CLK_DIV = 1,
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [7:0]        cmd_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              addr_en_i,
  input  logic [1:0]        addr_lanes_i,
  input  logic [4:0]        dummy_i,
  input  logic              release_i,
  output logic              sclk_o,
  output logic              cs_n_o,
  output logic [3:0]        io_o,
  output logic [3:0]        io_oe_o,
  output logic              busy_o,
  output logic              done_o
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, HOLD} state_t;
  localparam logic [3:0] HMAX = 4'(CLK_DIV - 1);
  localparam logic [15:0] A1 = 16'(ADDR_W);
  localparam logic [15:0] A2 = 16'(ADDR_W / 2);
  localparam logic [15:0] A4 = 16'(ADDR_W / 4);
  state_t state, state_nx;
  logic [3:0] hcnt;
  logic [15:0] pcnt, nper;
  logic [7:0] cmd_sr;
  logic [ADDR_W-1:0] addr_sr;
  logic addr_en;
  logic [1:0] lanes;
  logic [4:0] dummy;
  logic active, fall, last, dual, quad;
  always_comb begin
    dual = lanes == 2'b01;
    quad = lanes == 2'b10;
    active = state == CMD || state == ADDR || state == DUMMY;
    fall = active && sclk_o && hcnt == HMAX;
    nper = state == CMD ? 16'd8 : state == ADDR ? (dual ? A2 : quad ? A4 : A1) : {11'd0, dummy};
    last = pcnt == nper - 16'd1;
    state_nx = state == IDLE ? (start_i ? CMD : IDLE) :
               state == HOLD ? (release_i ? IDLE : HOLD) :
               !(fall && last) ? state :
               state == CMD && addr_en ? ADDR :
               state != DUMMY && dummy != 5'd0 ? DUMMY : HOLD;
    cs_n_o = state == IDLE;
    busy_o = state != IDLE;
    io_oe_o = state == CMD ? 4'b0001 : state == ADDR ? (quad ? 4'b1111 : dual ? 4'b0011 : 4'b0001) : 4'b0000;
    io_o = state == CMD ? {3'b000, cmd_sr[7]} :
           state == ADDR ? (quad ? addr_sr[ADDR_W-1 -: 4] : dual ? {2'b00, addr_sr[ADDR_W-1 -: 2]} : {3'b000, addr_sr[ADDR_W-1]}) :
           4'b0000;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sclk_o <= 1'b0;
      hcnt <= '0;
      pcnt <= '0;
      done_o <= 1'b0;
      cmd_sr <= '0;
      addr_sr <= '0;
      addr_en <= 1'b0;
      lanes <= '0;
      dummy <= '0;
    end else begin
      state <= state_nx;
      done_o <= state_nx == HOLD && state != HOLD;
      if (state == IDLE && start_i) begin
        cmd_sr <= cmd_i;
        addr_sr <= addr_i;
        addr_en <= addr_en_i;
        lanes <= addr_lanes_i;
        dummy <= dummy_i;
      end
      if (!active) begin
        hcnt <= '0;
        sclk_o <= 1'b0;
        pcnt <= '0;
      end else if (hcnt == HMAX) begin
        hcnt <= '0;
        sclk_o <= ~sclk_o;
        if (sclk_o) pcnt <= last ? 16'd0 : pcnt + 16'd1;
      end else hcnt <= hcnt + 4'd1;
      // data advances only on the falling SCK edge; phase changes reuse it
      if (fall && state == CMD) cmd_sr <= {cmd_sr[6:0], 1'b0};
      if (fall && state == ADDR) addr_sr <= quad ? addr_sr << 4 : dual ? addr_sr << 2 : addr_sr << 1;
    end
  end
endmodule

// File: tb/tb_qspi_cmd_shifter.sv
// tb_qspi_cmd_shifter: scoreboard bench for qspi_cmd_shifter at CLK_DIV 1 and 3
module tb_qspi_cmd_shifter;
  logic clk = 0, reset = 1, start1 = 0, start3 = 0, addr_en = 0, rel = 0, sel = 0;
  logic [7:0] cmd = 0;
  logic [23:0] addr = 0;
  logic [1:0] lanes = 0;
  logic [4:0] dummy = 0;
  logic s1, c1, b1, d1, s3, c3, b3, d3;
  logic [3:0] io1, oe1, io3, oe3;
  logic m_sclk, m_cs_n, m_busy, m_done;
  logic [3:0] m_io, m_oe;
  int n_chk = 0, n_fail = 0;
  logic [7:0] exp_q[$], obs_q[$];
  int run_q[$];

  always #5 clk = ~clk;

  qspi_cmd_shifter #(.CLK_DIV(1), .ADDR_W(24)) u1 (
    .clk(clk), .reset(reset), .start_i(start1), .cmd_i(cmd), .addr_i(addr), .addr_en_i(addr_en),
    .addr_lanes_i(lanes), .dummy_i(dummy), .release_i(rel), .sclk_o(s1), .cs_n_o(c1), .io_o(io1),
    .io_oe_o(oe1), .busy_o(b1), .done_o(d1));
  qspi_cmd_shifter #(.CLK_DIV(3), .ADDR_W(24)) u3 (
    .clk(clk), .reset(reset), .start_i(start3), .cmd_i(cmd), .addr_i(addr), .addr_en_i(addr_en),
    .addr_lanes_i(lanes), .dummy_i(dummy), .release_i(rel), .sclk_o(s3), .cs_n_o(c3), .io_o(io3),
    .io_oe_o(oe3), .busy_o(b3), .done_o(d3));

  assign m_sclk = sel ? s3 : s1;
  assign m_cs_n = sel ? c3 : c1;
  assign m_busy = sel ? b3 : b1;
  assign m_done = sel ? d3 : d1;
  assign m_io = sel ? io3 : io1;
  assign m_oe = sel ? oe3 : oe1;

  task automatic push_exp(input int div, input logic [7:0] c, input logic [23:0] a, input logic e,
                          input logic [1:0] l, input logic [4:0] d, output int lat);
    int n;
    exp_q.delete();
    cmd = c; addr = a; addr_en = e; lanes = l; dummy = d;
    for (int i = 7; i >= 0; i--) exp_q.push_back({4'b0001, 3'b000, c[i]});
    n = 8;
    if (e && l == 2'b10) begin
      for (int i = 5; i >= 0; i--) exp_q.push_back({4'b1111, a[i*4 +: 4]});
      n += 6;
    end else if (e && l == 2'b01) begin
      for (int i = 11; i >= 0; i--) exp_q.push_back({4'b0011, 2'b00, a[i*2 +: 2]});
      n += 12;
    end else if (e) begin
      for (int i = 23; i >= 0; i--) exp_q.push_back({4'b0001, 3'b000, a[i]});
      n += 24;
    end
    for (int i = 0; i < int'(d); i++) exp_q.push_back(8'h00);
    n += int'(d);
    lat = 2 * div * n;
  endtask

  task automatic collect(input int poke, input int budget, output int lat, output logic csn0, output logic tmo);
    int k, run;
    logic prev;
    obs_q.delete(); run_q.delete();
    if (sel) start3 = 1; else start1 = 1;
    @(negedge clk);
    start1 = 0; start3 = 0;
    k = 0; run = 0; prev = 0; tmo = 0; lat = -1;
    csn0 = m_cs_n;
    forever begin
      if (m_sclk !== prev) begin
        run_q.push_back(run);
        run = 0;
        prev = m_sclk;
        if (m_sclk) obs_q.push_back({m_oe, m_io});
      end
      run++;
      if (m_done) begin lat = k; break; end
      if (k >= budget) begin tmo = 1; break; end
      if (k == poke) begin
        if (sel) start3 = 1; else start1 = 1;
        cmd = ~cmd; addr = ~addr; lanes = ~lanes; dummy = ~dummy; addr_en = ~addr_en;
      end else begin
        start1 = 0; start3 = 0;
      end
      @(negedge clk);
      k++;
    end
    start1 = 0; start3 = 0;
  endtask

  task automatic test_reset;
    sel = 0;
    reset = 1;
    repeat (3) @(negedge clk);
    n_chk++; if (c1 !== 1'b1 || c3 !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n got %b/%b want 1/1", c1, c3); end
    n_chk++; if (s1 !== 1'b0 || s3 !== 1'b0) begin n_fail++; $display("FAIL reset_sclk got %b/%b want 0/0", s1, s3); end
    n_chk++; if ({oe1, io1} !== 8'h00) begin n_fail++; $display("FAIL reset_io got oe=%h io=%h want 0/0", oe1, io1); end
    n_chk++; if (b1 !== 1'b0 || d1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done got %b%b want 00", b1, d1); end
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_jedec;
    int lat, elat;
    logic csn0, tmo;
    logic [7:0] e, o;
    sel = 0;
    push_exp(1, 8'h9F, 24'h0, 0, 2'b00, 5'd0, elat);
    collect(-5, 200, lat, csn0, tmo);
    n_chk++; if (tmo || csn0 !== 1'b0) begin n_fail++; $display("FAIL jedec_start tmo=%b cs_n=%b want 0/0", tmo, csn0); end
    n_chk++; if (lat !== elat) begin n_fail++; $display("FAIL jedec_latency got %0d want %0d", lat, elat); end
    n_chk++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL jedec_periods got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : 8'hxx;
      n_chk++; if (o !== e) begin n_fail++; $display("FAIL jedec_bit got %h want %h", o, e); end
    end
    foreach (run_q[i]) begin
      n_chk++; if (run_q[i] !== 1) begin n_fail++; $display("FAIL jedec_halfperiod got %0d want 1", run_q[i]); end
    end
    n_chk++; if (m_busy !== 1'b1 || m_cs_n !== 1'b0 || m_oe !== 4'h0 || m_sclk !== 1'b0)
      begin n_fail++; $display("FAIL jedec_hold got busy=%b cs_n=%b oe=%h sclk=%b want 1/0/0/0", m_busy, m_cs_n, m_oe, m_sclk); end
    repeat (2) @(negedge clk);
    n_chk++; if (m_done !== 1'b0 || m_cs_n !== 1'b0) begin n_fail++; $display("FAIL jedec_hold2 got done=%b cs_n=%b want 0/0", m_done, m_cs_n); end
    rel = 1;
    @(negedge clk);
    rel = 0;
    n_chk++; if (m_cs_n !== 1'b1 || m_busy !== 1'b0) begin n_fail++; $display("FAIL jedec_release got cs_n=%b busy=%b want 1/0", m_cs_n, m_busy); end
  endtask

  task automatic test_read_1lane(input logic [1:0] l, input logic [7:0] c, input logic [23:0] a);
    int lat, elat;
    logic csn0, tmo;
    logic [7:0] e, o;
    sel = 0;
    push_exp(1, c, a, 1, l, 5'd0, elat);
    collect(-5, 400, lat, csn0, tmo);
    n_chk++; if (tmo || lat !== elat) begin n_fail++; $display("FAIL read1_latency got %0d want %0d (lanes %b)", lat, elat, l); end
    n_chk++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL read1_periods got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : 8'hxx;
      n_chk++; if (o !== e) begin n_fail++; $display("FAIL read1_bit got %h want %h (lanes %b)", o, e, l); end
    end
    rel = 1;
    @(negedge clk);
    rel = 0;
    n_chk++; if (m_cs_n !== 1'b1) begin n_fail++; $display("FAIL read1_release got cs_n=%b want 1", m_cs_n); end
  endtask

  task automatic test_quad;
    int lat, elat;
    logic csn0, tmo;
    logic [7:0] e, o;
    sel = 0;
    push_exp(1, 8'hEB, 24'h123456, 1, 2'b10, 5'd6, elat);
    collect(-5, 400, lat, csn0, tmo);
    n_chk++; if (tmo || lat !== 40 || elat !== 40) begin n_fail++; $display("FAIL quad_latency got %0d want 40", lat); end
    n_chk++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL quad_periods got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : 8'hxx;
      n_chk++; if (o !== e) begin n_fail++; $display("FAIL quad_period got %h want %h", o, e); end
    end
    rel = 1;
    @(negedge clk);
    rel = 0;
    n_chk++; if (m_cs_n !== 1'b1 || m_busy !== 1'b0) begin n_fail++; $display("FAIL quad_release_with_done got cs_n=%b busy=%b want 1/0", m_cs_n, m_busy); end
  endtask

  task automatic test_dual_div3;
    int lat, elat;
    logic csn0, tmo;
    logic [7:0] e, o;
    sel = 1;
    push_exp(3, 8'hBB, 24'hFFFF00, 1, 2'b01, 5'd4, elat);
    collect(-5, 1000, lat, csn0, tmo);
    n_chk++; if (tmo || lat !== 144 || elat !== 144) begin n_fail++; $display("FAIL div3_latency got %0d want 144", lat); end
    n_chk++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL div3_periods got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : 8'hxx;
      n_chk++; if (o !== e) begin n_fail++; $display("FAIL div3_period got %h want %h", o, e); end
    end
    foreach (run_q[i]) begin
      n_chk++; if (run_q[i] !== 3) begin n_fail++; $display("FAIL div3_halfperiod got %0d want 3", run_q[i]); end
    end
    rel = 1;
    @(negedge clk);
    rel = 0;
    n_chk++; if (m_cs_n !== 1'b1 || m_busy !== 1'b0) begin n_fail++; $display("FAIL div3_release got cs_n=%b busy=%b want 1/0", m_cs_n, m_busy); end
    sel = 0;
  endtask

  task automatic test_reset_mid;
    int lat, elat;
    logic csn0, tmo;
    logic [7:0] e, o;
    sel = 0;
    cmd = 8'h03; addr = 24'hA5C3F0; addr_en = 1; lanes = 2'b00; dummy = 5'd3;
    start1 = 1;
    @(negedge clk);
    start1 = 0;
    repeat (20) @(negedge clk);
    n_chk++; if (m_busy !== 1'b1 || m_oe !== 4'b0001) begin n_fail++; $display("FAIL midreset_pre got busy=%b oe=%h want 1/1", m_busy, m_oe); end
    reset = 1;
    @(negedge clk);
    n_chk++; if (m_cs_n !== 1'b1 || m_sclk !== 1'b0 || m_oe !== 4'h0 || m_busy !== 1'b0 || m_io !== 4'h0)
      begin n_fail++; $display("FAIL midreset got cs_n=%b sclk=%b oe=%h busy=%b io=%h want 1/0/0/0/0", m_cs_n, m_sclk, m_oe, m_busy, m_io); end
    reset = 0;
    @(negedge clk);
    push_exp(1, 8'h9F, 24'h0, 0, 2'b00, 5'd0, elat);
    collect(-5, 200, lat, csn0, tmo);
    n_chk++; if (tmo || lat !== elat) begin n_fail++; $display("FAIL midreset_rerun_latency got %0d want %0d", lat, elat); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : 8'hxx;
      n_chk++; if (o !== e) begin n_fail++; $display("FAIL midreset_rerun_bit got %h want %h", o, e); end
    end
    rel = 1;
    @(negedge clk);
    rel = 0;
  endtask

  task automatic test_ignore_start;
    int lat, elat;
    logic csn0, tmo, saw_sclk;
    logic [7:0] e, o;
    sel = 0;
    push_exp(1, 8'h05, 24'h0, 0, 2'b00, 5'd0, elat);
    collect(5, 200, lat, csn0, tmo);
    n_chk++; if (tmo || lat !== elat) begin n_fail++; $display("FAIL ignore_cmd_latency got %0d want %0d", lat, elat); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : 8'hxx;
      n_chk++; if (o !== e) begin n_fail++; $display("FAIL ignore_cmd_bit got %h want %h", o, e); end
    end
    cmd = 8'hAA; addr_en = 0; dummy = 0;
    start1 = 1;
    @(negedge clk);
    start1 = 0;
    saw_sclk = 0;
    repeat (4) begin
      saw_sclk |= m_sclk;
      @(negedge clk);
    end
    n_chk++; if (m_busy !== 1'b1 || m_cs_n !== 1'b0 || saw_sclk !== 1'b0 || m_done !== 1'b0)
      begin n_fail++; $display("FAIL ignore_hold got busy=%b cs_n=%b sclk_seen=%b done=%b want 1/0/0/0", m_busy, m_cs_n, saw_sclk, m_done); end
    rel = 1;
    @(negedge clk);
    rel = 0;
    n_chk++; if (m_busy !== 1'b0 || m_cs_n !== 1'b1) begin n_fail++; $display("FAIL ignore_release got busy=%b cs_n=%b want 0/1", m_busy, m_cs_n); end
    push_exp(1, 8'hAA, 24'h0, 0, 2'b00, 5'd0, elat);
    collect(-5, 200, lat, csn0, tmo);
    n_chk++; if (tmo || lat !== elat || csn0 !== 1'b0) begin n_fail++; $display("FAIL ignore_next_latency got %0d want %0d", lat, elat); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : 8'hxx;
      n_chk++; if (o !== e) begin n_fail++; $display("FAIL ignore_next_bit got %h want %h", o, e); end
    end
    rel = 1;
    @(negedge clk);
    rel = 0;
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_jedec;
    test_read_1lane(2'b00, 8'h03, 24'hA5C3F0);
    test_read_1lane(2'b11, 8'h0B, 24'h3C0F81);
    test_quad;
    test_dual_div3;
    test_reset_mid;
    test_ignore_start;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
